// File: rtl/angle_sweep_ctrl.sv
// Angle sweep sequencer for the trig LUT: steps an angle, reads sin then cos,
// and presents {angle, sin, cos} triples on a valid/ready output.
module angle_sweep_ctrl #(
  parameter int LAT     = 1,
  parameter int ANG_MAX = 3600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [11:0] start_deg,
  input  logic [11:0] step,
  input  logic [11:0] n_points,
  output logic [11:0] degree,
  output logic        iscos,
  input  logic [9:0]  value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] angle_out,
  output logic [9:0]  sin_out,
  output logic [9:0]  cos_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SIN_WAIT = 2'd1,
    COS_WAIT = 2'd2,
    OUT      = 2'd3
  } state_t;

  localparam logic [12:0] ANG_MAX_C = 13'(ANG_MAX);
  localparam logic [2:0]  LAT_C     = 3'(LAT);

  // Sum fits in 13 bits (3599 + 4095); two conditional subtractions fold it back.
  function automatic logic [11:0] wrap_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= ANG_MAX_C) s = s - ANG_MAX_C;
    if (s >= ANG_MAX_C) s = s - ANG_MAX_C;
    return s[11:0];
  endfunction

  function automatic logic [11:0] clamp_ang(input logic [11:0] a);
    return ({1'b0, a} >= ANG_MAX_C) ? 12'd0 : a;
  endfunction

  state_t      state, state_nxt;
  logic [2:0]  wcnt;
  logic [11:0] angle;
  logic [11:0] step_q;
  logic [11:0] npts_q;
  logic [11:0] pcnt;
  logic [11:0] pcnt_inc;
  logic [11:0] angle_nxt;
  logic        wait_end;
  logic        last_pt;
  logic        ld_start, cap_sin, cap_cos, adv, fin, abort;

  assign pcnt_inc  = pcnt + 12'd1;
  assign angle_nxt = wrap_add(angle, step_q);
  assign wait_end  = (wcnt == LAT_C);
  assign last_pt   = (npts_q != 12'd0) && (pcnt_inc == npts_q);

  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    ld_start  = 1'b0;
    cap_sin   = 1'b0;
    cap_cos   = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          ld_start  = 1'b1;
          state_nxt = SIN_WAIT;
        end
      end
      SIN_WAIT: begin
        if (stop) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (wait_end) begin
          cap_sin   = 1'b1;
          state_nxt = COS_WAIT;
        end
      end
      COS_WAIT: begin
        if (stop) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (wait_end) begin
          cap_cos   = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        // stop beats a same-cycle accept: the triple is dropped and not counted
        if (stop) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (out_ready) begin
          if (last_pt) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end else begin
            adv       = 1'b1;
            state_nxt = SIN_WAIT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= 3'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= fin;
      if ((state == SIN_WAIT || state == COS_WAIT) && !wait_end && !stop)
        wcnt <= wcnt + 3'd1;
      else
        wcnt <= 3'd0;
    end
  end

  // degree/iscos only move on state transitions so the LUT sees stable inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle     <= 12'd0;
      step_q    <= 12'd0;
      npts_q    <= 12'd0;
      pcnt      <= 12'd0;
      degree    <= 12'd0;
      iscos     <= 1'b0;
      angle_out <= 12'd0;
      sin_out   <= 10'd0;
      cos_out   <= 10'd0;
    end else begin
      if (ld_start) begin
        step_q <= step;
        npts_q <= n_points;
        angle  <= clamp_ang(start_deg);
        degree <= clamp_ang(start_deg);
        pcnt   <= 12'd0;
      end
      if (cap_sin)
        sin_out <= value;
      if (cap_cos) begin
        cos_out   <= value;
        angle_out <= angle;
      end
      if (adv) begin
        angle  <= angle_nxt;
        degree <= angle_nxt;
      end
      if (adv || fin)
        pcnt <= pcnt_inc;
      if (cap_sin)
        iscos <= 1'b1;
      else if (ld_start || adv || fin || abort)
        iscos <= 1'b0;
    end
  end

endmodule
